// File: rtl/serial_mag_comparator_pkg.sv
// Shared definitions for the bit-serial magnitude comparator.
// FSM state encodings used by the top-level control.
package serial_mag_comparator_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPARE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

endpackage

// File: rtl/serial_mag_comparator_if.sv
// Operand-bit stream and result bundle of the serial comparator.
// The master drives operand bits; the slave returns status and G/L/E.
interface serial_mag_comparator_if;

  logic start;
  logic bit_valid;
  logic a_bit;
  logic b_bit;
  logic busy;
  logic done;
  logic G;
  logic L;
  logic E;

  modport master (
    output start, bit_valid, a_bit, b_bit,
    input  busy, done, G, L, E
  );

  modport slave (
    input  start, bit_valid, a_bit, b_bit,
    output busy, done, G, L, E
  );

endinterface

// File: rtl/serial_mag_comparator_comparator1bit.sv
// Single-bit magnitude stage: flags a > b and a < b.
// Equality is implied when neither flag is set.
module comparator1bit (
  input  logic a,
  input  logic b,
  output logic g,
  output logic l
);

  assign g = a & ~b;
  assign l = ~a & b;

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial N-bit magnitude comparator, operands MSB first.
// The first differing bit decides; G/L/E are registered and held.
module serial_mag_comparator
  import serial_mag_comparator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  serial_mag_comparator_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          gt;
  logic          lt;
  logic          decided;
  logic          g_q;
  logic          l_q;
  logic          e_q;
  logic          sg;
  logic          sl;
  logic          dec_n;
  logic          gt_n;
  logic          lt_n;

  comparator1bit u_stage (
    .a (bus.a_bit),
    .b (bus.b_bit),
    .g (sg),
    .l (sl)
  );

  // Decision including the pair on the wires, so the last pair counts
  always_comb begin
    dec_n = decided;
    gt_n  = gt;
    lt_n  = lt;
    if (!decided && (sg || sl)) begin
      dec_n = 1'b1;
      gt_n  = sg;
      lt_n  = sl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      gt      <= 1'b0;
      lt      <= 1'b0;
      decided <= 1'b0;
      g_q     <= 1'b0;
      l_q     <= 1'b0;
      e_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state   <= ST_COMPARE;
            cnt     <= '0;
            gt      <= 1'b0;
            lt      <= 1'b0;
            decided <= 1'b0;
            g_q     <= 1'b0;
            l_q     <= 1'b0;
            e_q     <= 1'b0;
          end
        end
        ST_COMPARE: begin
          if (bus.bit_valid) begin
            decided <= dec_n;
            gt      <= gt_n;
            lt      <= lt_n;
            if (cnt == LAST) begin
              state <= ST_DONE;
              g_q   <= gt_n;
              l_q   <= lt_n;
              e_q   <= ~dec_n;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = (state == ST_COMPARE);
  assign bus.done = (state == ST_DONE);
  assign bus.G    = g_q;
  assign bus.L    = l_q;
  assign bus.E    = e_q;

endmodule
